// File: rtl/fft_pkg.sv
// Shared FFT front-end types and constants.
// Frame geometry and complex sample layout.
package fft_pkg;

    localparam int unsigned D_WIDTH     = 64;
    localparam int unsigned LOG_2_WIDTH = 6;
    localparam int unsigned S_WIDTH     = 16;

    typedef logic signed [S_WIDTH-1:0] fft_sample_t;

    typedef struct packed {
        fft_sample_t re;
        fft_sample_t im;
    } fft_cplx_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer bank: D_WIDTH complex registers
// with an indexed write port and a FULL flag.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [LOG_2_WIDTH-1:0] idx,
    input  fft_cplx_t              wdata,
    input  logic                   set_full,
    input  logic                   clr_full,
    output logic                   full,
    output fft_cplx_t              data [D_WIDTH]
);

    fft_cplx_t mem_q [D_WIDTH];
    fft_cplx_t mem_d [D_WIDTH];
    logic      full_q;
    logic      full_d;

    // Write the addressed entry and update the FULL flag
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[idx] = wdata;
        end
        full_d = full_q;
        if (set_full) begin
            full_d = 1'b1;
        end else if (clr_full) begin
            full_d = 1'b0;
        end
    end

    // Bank storage and flag, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(D_WIDTH); i++) begin
                mem_q[i] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            full_q <= full_d;
        end
    end

    assign full = full_q;
    assign data = mem_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Serial-to-parallel ping-pong frame loader that feeds
// the FFT bit-reversal router with whole frames.
module fft_sample_loader
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [S_WIDTH-1:0]     in_re,
    input  logic [S_WIDTH-1:0]     in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [S_WIDTH-1:0]     out_re [D_WIDTH],
    output logic [S_WIDTH-1:0]     out_im [D_WIDTH],
    output logic [LOG_2_WIDTH-1:0] wr_count
);

    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [LOG_2_WIDTH-1:0] wr_idx_q, wr_idx_d;

    logic [1:0] full;
    logic [1:0] we;
    logic [1:0] set_full;
    logic [1:0] clr_full;
    logic       accept;
    logic       last;
    logic       consume;
    fft_cplx_t  wdata;
    fft_cplx_t  bank0_data [D_WIDTH];
    fft_cplx_t  bank1_data [D_WIDTH];

    assign in_ready = ~full[wr_bank_q] & ~clear;
    assign accept   = in_valid & in_ready;
    assign last     = (wr_idx_q == LOG_2_WIDTH'(D_WIDTH - 1));
    assign consume  = full[rd_bank_q] & out_ready;
    assign wdata    = '{re: in_re, im: in_im};

    // Pointer advance and per-bank write/flag strobes
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        we        = '0;
        set_full  = '0;
        clr_full  = '0;
        if (clear) begin
            wr_idx_d = '0;
        end else if (accept) begin
            we[wr_bank_q] = 1'b1;
            wr_idx_d      = wr_idx_q + 1'b1;
            if (last) begin
                set_full[wr_bank_q] = 1'b1;
                wr_bank_d           = ~wr_bank_q;
            end
        end
        if (consume) begin
            clr_full[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
        end
    end

    // Write/read pointers and fill index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    fft_frame_bank u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we[0]),
        .idx      (wr_idx_q),
        .wdata    (wdata),
        .set_full (set_full[0]),
        .clr_full (clr_full[0]),
        .full     (full[0]),
        .data     (bank0_data)
    );

    fft_frame_bank u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we[1]),
        .idx      (wr_idx_q),
        .wdata    (wdata),
        .set_full (set_full[1]),
        .clr_full (clr_full[1]),
        .full     (full[1]),
        .data     (bank1_data)
    );

    // Present the read bank; purely a mux of registered state
    always_comb begin
        for (int k = 0; k < int'(D_WIDTH); k++) begin
            out_re[k] = rd_bank_q ? bank1_data[k].re : bank0_data[k].re;
            out_im[k] = rd_bank_q ? bank1_data[k].im : bank0_data[k].im;
        end
    end

    assign out_valid = full[rd_bank_q];
    assign wr_count  = wr_idx_q;

endmodule
